// File: rtl/cache_nway_ctrl.sv
// cache_nway_ctrl
// N-way set-associative write-through cache with per-set LRU ages and a
// single-outstanding-request controller between the CPU port and RAM.
//
// Ports
//   clk, gen_reset_n        clock, asynchronous active-low reset
//   flush                   invalidate every line (taken only in IDLE, beats cpu_req)
//   cpu_req/cpu_ready       request handshake; accepted when both high at an edge
//   cpu_we/cpu_be/cpu_addr/cpu_wdata   request attributes
//   cpu_done/cpu_hit/cpu_rdata         one-cycle completion, hit flag, read data
//   ram_req/ram_we/ram_addr/ram_be/ram_wdata   RAM request, held until ram_ack
//   ram_ack/ram_rdata       RAM completion and read data (same cycle)
//   hit_count/miss_count    saturating statistics
module cache_nway_ctrl #(
  parameter int bitsDirect  = 10,
  parameter int sizeBitLine = 64,
  parameter int WAYS        = 4,
  parameter int SETS        = 16
) (
  input  logic                     clk,
  input  logic                     gen_reset_n,
  input  logic                     flush,
  input  logic                     cpu_req,
  output logic                     cpu_ready,
  input  logic                     cpu_we,
  input  logic [sizeBitLine/8-1:0] cpu_be,
  input  logic [bitsDirect-1:0]    cpu_addr,
  input  logic [sizeBitLine-1:0]   cpu_wdata,
  output logic                     cpu_done,
  output logic                     cpu_hit,
  output logic [sizeBitLine-1:0]   cpu_rdata,
  output logic                     ram_req,
  output logic                     ram_we,
  output logic [bitsDirect-1:0]    ram_addr,
  output logic [sizeBitLine/8-1:0] ram_be,
  output logic [sizeBitLine-1:0]   ram_wdata,
  input  logic                     ram_ack,
  input  logic [sizeBitLine-1:0]   ram_rdata,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = bitsDirect - IW;
  localparam int AW = $clog2(WAYS);
  localparam int BW = sizeBitLine / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_WRITE_RAM,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  // Registered request
  logic [bitsDirect-1:0]  req_addr;
  logic                   req_we;
  logic [BW-1:0]          req_be;
  logic [sizeBitLine-1:0] req_wdata;
  logic                   req_hit;

  logic [IW-1:0] req_set;
  logic [TW-1:0] req_tag;
  assign req_set = req_addr[IW-1:0];
  assign req_tag = req_addr[bitsDirect-1:IW];

  // Cache storage
  logic [sizeBitLine-1:0] data_mem [SETS][WAYS];
  logic [TW-1:0]          tag_mem  [SETS][WAYS];
  logic [WAYS-1:0]        valid_q  [SETS];
  logic [AW-1:0]          age_q    [SETS][WAYS];

  logic                   accept;
  logic                   lookup_hit;
  logic [AW-1:0]          hit_way;
  logic                   victim_found;
  logic [AW-1:0]          victim_way;
  logic                   touch_en;
  logic [AW-1:0]          touch_way;
  logic                   line_we;
  logic                   tag_we;
  logic [AW-1:0]          line_way;
  logic [sizeBitLine-1:0] line_data;

  function automatic logic [sizeBitLine-1:0] merge_bytes(
    input logic [sizeBitLine-1:0] old_data,
    input logic [BW-1:0]          be,
    input logic [sizeBitLine-1:0] wdata
  );
    logic [sizeBitLine-1:0] res;
    res = old_data;
    for (int unsigned b = 0; b < BW; b++) begin
      if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  assign cpu_ready = (state_q == S_IDLE) && !flush;
  assign accept    = cpu_ready && cpu_req;

  // Tag compare across the set; at most one valid way can match.
  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_set][w] && (tag_mem[req_set][w] == req_tag)) begin
        lookup_hit = 1'b1;
        hit_way    = AW'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the oldest (age WAYS-1).
  always_comb begin
    victim_found = 1'b0;
    victim_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[req_set][w]) begin
        victim_found = 1'b1;
        victim_way   = AW'(w);
      end
    end
    if (!victim_found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[req_set][w] == AW'(WAYS - 1)) victim_way = AW'(w);
      end
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush)        state_d = S_FLUSH;
        else if (cpu_req) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (req_we)          state_d = S_WRITE_RAM;
        else if (lookup_hit) state_d = S_IDLE;
        else                 state_d = S_REFILL;
      end
      S_REFILL:    if (ram_ack) state_d = S_IDLE;
      S_WRITE_RAM: if (ram_ack) state_d = S_IDLE;
      S_FLUSH:     state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Array update controls (LRU touch, line/tag writes)
  always_comb begin
    touch_en  = 1'b0;
    touch_way = hit_way;
    line_we   = 1'b0;
    tag_we    = 1'b0;
    line_way  = hit_way;
    line_data = merge_bytes(data_mem[req_set][hit_way], req_be, req_wdata);
    if (state_q == S_LOOKUP && lookup_hit) begin
      touch_en = 1'b1;
      line_we  = req_we;
    end else if (state_q == S_REFILL && ram_ack) begin
      touch_en  = 1'b1;
      touch_way = victim_way;
      line_we   = 1'b1;
      tag_we    = 1'b1;
      line_way  = victim_way;
      line_data = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Data and tags need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) data_mem[req_set][line_way] <= line_data;
    if (tag_we)  tag_mem[req_set][line_way]  <= req_tag;
  end

  // Valid bits and LRU ages
  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      end
    end else if (state_q == S_FLUSH) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      end
    end else if (touch_en) begin
      // Ways younger than the touched one age by one; the touched way becomes 0.
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (AW'(w) == touch_way)
          age_q[req_set][w] <= '0;
        else if (age_q[req_set][w] < age_q[req_set][touch_way])
          age_q[req_set][w] <= age_q[req_set][w] + 1'b1;
      end
      if (tag_we) valid_q[req_set][touch_way] <= 1'b1;
    end
  end

  // Request registers, CPU/RAM outputs and counters
  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      req_addr   <= '0;
      req_we     <= 1'b0;
      req_be     <= '0;
      req_wdata  <= '0;
      req_hit    <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_rdata  <= '0;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_be     <= '0;
      ram_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_addr  <= cpu_addr;
            req_we    <= cpu_we;
            req_be    <= cpu_be;
            req_wdata <= cpu_wdata;
          end
        end
        S_LOOKUP: begin
          req_hit <= lookup_hit;
          if (lookup_hit) hit_count  <= sat_inc(hit_count);
          else            miss_count <= sat_inc(miss_count);
          if (req_we) begin
            ram_req   <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= req_addr;
            ram_be    <= req_be;
            ram_wdata <= req_wdata;
          end else if (lookup_hit) begin
            cpu_done  <= 1'b1;
            cpu_hit   <= 1'b1;
            cpu_rdata <= data_mem[req_set][hit_way];
          end else begin
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= req_addr;
            ram_be    <= '1;
            ram_wdata <= '0;
          end
        end
        S_REFILL: begin
          if (ram_ack) begin
            ram_req   <= 1'b0;
            cpu_done  <= 1'b1;
            cpu_hit   <= 1'b0;
            cpu_rdata <= ram_rdata;
          end
        end
        S_WRITE_RAM: begin
          if (ram_ack) begin
            ram_req  <= 1'b0;
            cpu_done <= 1'b1;
            cpu_hit  <= req_hit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cache_nway_ctrl.md
# cache_nway_ctrl

Parameterised N-way set-associative cache with integrated tag, valid and LRU state and a single-outstanding-request controller. It sits between the CPU load/store port and the RAM port and generalises the fixed 4-block data array to configurable ways, sets and line width. It adds the following behaviour:
- hit detection;
- LRU replacement;
- miss refill from RAM;
- write-through with byte lanes;
- flush and hit/miss statistics.

## Interface
Parameters:
- `bitsDirect`, 10: word address width.
- `sizeBitLine`, 64: line width; one word per line; must be a multiple of 8.
- `WAYS`, 4: associativity; power of two, 2..8.
- `SETS`, 16: number of sets; power of two; tag width `TW` = `bitsDirect` − log2(`SETS`).

Ports:
- `clk`  in  1: rising-edge clock.
- `gen_reset_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: invalidate all lines; sampled only in IDLE.
- `cpu_req`  in  1: CPU request.
- `cpu_ready`  out  1: high only in IDLE with `flush`=0. A request is accepted on an edge where `cpu_req`&`cpu_ready`.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_be`  in  `sizeBitLine`/8: byte enables for writes.
- `cpu_addr`  in  `bitsDirect`: index = low log2(`SETS`) bits, tag = upper bits.
- `cpu_wdata`  in  `sizeBitLine`: write data.
- `cpu_done`  out  1: one-cycle completion pulse.
- `cpu_hit`  out  1: valid with `cpu_done`; 1 if the request hit.
- `cpu_rdata`  out  `sizeBitLine`: read data, valid with `cpu_done` on reads.
- `ram_req`  out  1: RAM request, held until acknowledged.
- `ram_we`  out  1: RAM write.
- `ram_addr`  out  `bitsDirect`: RAM address.
- `ram_be`  out  `sizeBitLine`/8: RAM byte enables.
- `ram_wdata`  out  `sizeBitLine`: RAM write data.
- `ram_ack`  in  1: RAM completion; `ram_rdata` is valid in the same cycle for reads.
- `ram_rdata`  in  `sizeBitLine`: RAM read data.
- `hit_count`, `miss_count`  out  16: saturating statistics counters.

## Operation
- States: IDLE, LOOKUP, REFILL, WRITE_RAM, FLUSH.
- IDLE:
  - `flush`=1 → FLUSH; flush has priority over `cpu_req`.
  - Otherwise an accepted request registers addr/we/be/wdata → LOOKUP.
- LOOKUP: compare the registered tag against all valid ways of the set; at most one way may match.
  - Read hit: `cpu_rdata` ← way data, `cpu_done`=1, `cpu_hit`=1, LRU touch, `hit_count`+1 → IDLE.
  - Read miss: `ram_req`=1, `ram_we`=0, `ram_addr`=registered addr, `miss_count`+1 → REFILL.
  - Write, hit or miss: on hit, merge enabled bytes into the way and touch LRU. Drive `ram_req`=1, `ram_we`=1, `ram_be`/`ram_wdata`/`ram_addr` from the registers. Count a hit or a miss → WRITE_RAM. Write misses do not allocate.
- REFILL: wait for `ram_ack`. On ack:
  - Victim = lowest-index invalid way, else the way with age `WAYS`−1.
  - Write `ram_rdata` and the tag into the victim, set valid, touch LRU.
  - Assert `cpu_rdata`=`ram_rdata`, `cpu_done`=1, `cpu_hit`=0 (reflects the original lookup); `ram_req`=0 → IDLE.
- WRITE_RAM: on `ram_ack`, `ram_req`=0, `cpu_done`=1, `cpu_hit` = lookup result → IDLE.
- LRU uses a `log2(WAYS)`-bit age per way per set. Touching way w: every way with age < age[w] increments, and age[w] ← 0. Ages always form a permutation of 0..`WAYS`−1.
- FLUSH: one cycle; clears all valid bits, resets ages to the way index, then → IDLE. Data and counters are untouched.
- Counters saturate at 16'hFFFF.
- `ram_*` outputs stay stable while `ram_req`=1.
- `ram_ack` outside REFILL/WRITE_RAM is ignored.

## Timing
- Reset (async assert, clk-synchronous deassert handled upstream):
  - State IDLE; all valid bits 0; ages = way index.
  - `cpu_ready`=1, `cpu_done`=0, `cpu_hit`=0, `cpu_rdata`=0.
  - `ram_req`=0, `ram_we`=0, `ram_addr`/`ram_be`/`ram_wdata`=0.
  - Counters 0.
- Reset mid-REFILL/WRITE_RAM drops `ram_req` immediately and the request is lost.
- Accept at edge E0 → LOOKUP during the E0–E1 cycle.
- Read hit: `cpu_done` high E1–E2; next accept possible at E2 (peak throughput 1 request per 2 cycles).
- Miss / write: `ram_req` high from E1. `ram_ack` sampled at edge Ek → `cpu_done` high Ek–Ek+1, `ram_req` low after Ek. Minimum is `ram_ack` at E2.
- `cpu_done` is never high for more than one cycle.
- FLUSH accepted at E0 → `cpu_ready` low E0–E1, high from E1.
- Outputs are registered; no combinational path from `cpu_*` inputs to `ram_*` outputs.

## Test plan
- Reset: hold `gen_reset_n`=0 mid-REFILL → `ram_req`=0 asynchronously, all outputs at reset values. Then read addr 0x000 → miss, `miss_count`=1.
- Cold read addr 0x123, RAM returns 64'hDEAD_BEEF_0000_0001 with ack at E3 → `cpu_done` E3–E4, `cpu_hit`=0. Re-read → `cpu_done` at E1 with the same data, `cpu_hit`=1, `hit_count`=1, no `ram_req`.
- WAYS=4, SETS=16: read tags 1..4 in set 5, re-read tag 1, then read tag 5 in set 5 → tag 2's way is evicted. A subsequent read of tag 2 misses; a read of tag 1 hits.
- Write hit to a cached line of 64'h0 with `cpu_be`=8'h0F, `cpu_wdata`=64'h1111_2222_3333_4444 → RAM write with `ram_be`=8'h0F. Following read hits with 64'h0000_0000_3333_4444.
- Write miss to an uncached address → RAM write only. Following read of that address misses (no allocate).
- `flush` asserted together with `cpu_req` → FLUSH taken first, `cpu_ready` low one cycle. Previously hitting lines now miss; counters unchanged by the flush.
